hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port ID_valid, input, 1 bit: a real instruction is present in ID.
REQ-004 The block SHALL have the port ID_OPcode, input, 6 bits: opcode of the ID instruction.
REQ-005 The block SHALL have the ports ID_rs, ID_rt and ID_rd, inputs, 5 bits each: register fields of the ID instruction.
REQ-006 The block SHALL have the port Flush, input, 1 bit: the ID instruction is squashed because a branch was taken.
REQ-007 The block SHALL have the port Stall, output, 1 bit: freeze PC and IF/ID, and insert a bubble into ID/EX.
REQ-008 The block SHALL have the ports ID_EX_RegWrite (output, 1 bit) and ID_EX_dst (output, 5 bits): the EX-stage writer.
REQ-009 The block SHALL have the ports EX_MEM_RegWrite (output, 1 bit) and EX_MEM_dst (output, 5 bits): the MEM-stage writer, consumed by forwarding.
REQ-010 The block SHALL have the ports MEM_WB_RegWrite (output, 1 bit) and MEM_WB_dst (output, 5 bits): the WB-stage writer, consumed by forwarding.
REQ-011 The block SHALL have the port Stall_count, output, 16 bits: number of load-use stall cycles since reset.

Function
REQ-012 The block SHALL decode ID_OPcode as follows: 000000 (R-type) writes rd, reads rs and rt; 001000 (addi) writes rt, reads rs; 100011 (lw) writes rt, reads rs, and is a load; 101011 (sw) and 000100 (beq) do not write and read rs and rt; all other opcodes do not write and read rs only.
REQ-013 The block SHALL set decoded RegWrite to 0 whenever the decoded destination is 5'b00000 or ID_valid is 0.
REQ-014 The block SHALL hold three registered stage entries, ID_EX, EX_MEM and MEM_WB, each of {RegWrite, dst}, plus an ID_EX_load flag.
REQ-015 Every cycle, the block SHALL advance MEM_WB <= EX_MEM and EX_MEM <= ID_EX; these always advance, including during Stall.
REQ-016 Every cycle, the block SHALL load ID_EX with the decoded ID instruction, unless Stall or Flush is 1, in which case it SHALL load a bubble (RegWrite=0, dst=0, load=0).
REQ-017 Stall SHALL be combinational from registered state and ID inputs: Stall = ID_valid & !Flush & ID_EX_load & ID_EX_RegWrite & ((ID_EX_dst==ID_rs) | (reads_rt & ID_EX_dst==ID_rt)).
REQ-018 A load-use hazard SHALL produce exactly one Stall cycle, because the bubble clears ID_EX_load on the next edge; back-to-back lw/use pairs SHALL each produce one stall.
REQ-019 Flush SHALL take priority over Stall: when both conditions hold, Stall SHALL be 0 and a bubble SHALL be inserted.
REQ-020 Stall_count SHALL increment by 1 on each edge where Stall is 1, and SHALL saturate at 16'hFFFF without wrap-around.
REQ-021 A lw into $0 SHALL never cause a stall, since RegWrite is 0 per REQ-013.
REQ-022 The outputs SHALL be driven directly from the stage registers, with no added latency.

Reset
REQ-023 While rst=1, all stage entries SHALL be bubbles (all RegWrite=0, all dst=0, load=0), Stall_count SHALL be 0, and Stall SHALL be 0.
REQ-024 An assertion of rst in the middle of an operation SHALL discard any pending stall immediately, and the first edge after release SHALL capture the ID instruction normally.

Verification
REQ-025 The bench SHALL cover: R-type add rd=3 in ID, no hazards -> ID_EX_dst=3 after 1 edge, EX_MEM_dst=3 after 2 edges, MEM_WB_dst=3 after 3 edges, each with RegWrite=1; Stall=0 throughout.
REQ-026 The bench SHALL cover: lw rt=5 followed by add rs=5 -> Stall=1 for exactly one cycle, ID_EX shows a bubble next, then add enters ID_EX; Stall_count=1.
REQ-027 The bench SHALL cover: lw rt=5 followed by addi rs=2, rt=5 -> no stall, since addi does not read rt; lw rt=5 followed by sw rt=5 -> one stall.
REQ-028 The bench SHALL cover: lw rt=0 followed by add rs=0 -> Stall=0 and ID_EX_RegWrite=0.
REQ-029 The bench SHALL cover: lw rt=7, then add rs=7 with Flush=1 -> Stall=0, a bubble is inserted, and Stall_count is unchanged.
REQ-030 The bench SHALL cover: rst pulsed while Stall=1 -> all outputs read 0 immediately; Stall_count preset near 16'hFFFF with repeated hazards -> it holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks EX/MEM/WB register writers and
// raises a one-cycle load-use stall, with a saturating stall counter.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_valid,
  input  logic [5:0]  ID_OPcode,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [4:0]  ID_rd,
  input  logic        Flush,
  output logic        Stall,
  output logic        ID_EX_RegWrite,
  output logic [4:0]  ID_EX_dst,
  output logic        EX_MEM_RegWrite,
  output logic [4:0]  EX_MEM_dst,
  output logic        MEM_WB_RegWrite,
  output logic [4:0]  MEM_WB_dst,
  output logic [15:0] Stall_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic       we;
    logic [4:0] dst;
  } stage_t;

  localparam stage_t BUBBLE = '{we: 1'b0, dst: 5'd0};

  logic is_r;
  logic is_addi;
  logic is_lw;
  logic is_sw;
  logic is_beq;

  logic [4:0] dec_dst;
  logic       dec_wr;
  logic       dec_ld;
  logic       reads_rt;

  stage_t dec;
  logic   dec_load;

  stage_t id_ex_q;
  stage_t ex_mem_q;
  stage_t mem_wb_q;
  logic   id_ex_ld_q;

  logic [15:0] stall_cnt_q;

  logic hit_rs;
  logic hit_rt;
  logic bubble;

  assign is_r    = (ID_OPcode == OP_R);
  assign is_addi = (ID_OPcode == OP_ADDI);
  assign is_lw   = (ID_OPcode == OP_LW);
  assign is_sw   = (ID_OPcode == OP_SW);
  assign is_beq  = (ID_OPcode == OP_BEQ);

  // Opcode decode: destination, write, load and rt-use flags.
  always_comb begin
    dec_dst  = 5'd0;
    dec_wr   = 1'b0;
    dec_ld   = 1'b0;
    reads_rt = 1'b0;
    unique case (1'b1)
      is_r: begin
        dec_dst  = ID_rd;
        dec_wr   = 1'b1;
        reads_rt = 1'b1;
      end
      is_addi: begin
        dec_dst = ID_rt;
        dec_wr  = 1'b1;
      end
      is_lw: begin
        dec_dst = ID_rt;
        dec_wr  = 1'b1;
        dec_ld  = 1'b1;
      end
      is_sw: begin
        reads_rt = 1'b1;
      end
      is_beq: begin
        reads_rt = 1'b1;
      end
      default: begin
        dec_dst  = 5'd0;
      end
    endcase
  end

  // Writes to $0 and empty slots never count as writers.
  always_comb begin
    dec.dst  = dec_dst;
    dec.we   = ID_valid & dec_wr & (|dec_dst);
    dec_load = ID_valid & dec_ld;
  end

  // Load-use detect against the load sitting in EX; Flush wins.
  always_comb begin
    hit_rs = (id_ex_q.dst == ID_rs);
    hit_rt = reads_rt & (id_ex_q.dst == ID_rt);
    Stall  = ID_valid & ~Flush
           & id_ex_ld_q & id_ex_q.we
           & (hit_rs | hit_rt);
    bubble = Stall | Flush;
  end

  // ID/EX entry: decoded instruction or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q    <= BUBBLE;
      id_ex_ld_q <= 1'b0;
    end else if (bubble) begin
      id_ex_q    <= BUBBLE;
      id_ex_ld_q <= 1'b0;
    end else begin
      id_ex_q    <= dec;
      id_ex_ld_q <= dec_load;
    end
  end

  // Downstream stages shift unconditionally, even during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_q <= BUBBLE;
      mem_wb_q <= BUBBLE;
    end else begin
      ex_mem_q <= id_ex_q;
      mem_wb_q <= ex_mem_q;
    end
  end

  // Stall-cycle counter, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (Stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign ID_EX_RegWrite  = id_ex_q.we;
  assign ID_EX_dst       = id_ex_q.dst;
  assign EX_MEM_RegWrite = ex_mem_q.we;
  assign EX_MEM_dst      = ex_mem_q.dst;
  assign MEM_WB_RegWrite = mem_wb_q.we;
  assign MEM_WB_dst      = mem_wb_q.dst;
  assign Stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic,
// checked every cycle against a pipeline-history model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ID_valid = 1'b0;
  logic [5:0]  ID_OPcode = 6'd0;
  logic [4:0]  ID_rs = 5'd0;
  logic [4:0]  ID_rt = 5'd0;
  logic [4:0]  ID_rd = 5'd0;
  logic        Flush = 1'b0;
  logic        Stall;
  logic        ID_EX_RegWrite;
  logic [4:0]  ID_EX_dst;
  logic        EX_MEM_RegWrite;
  logic [4:0]  EX_MEM_dst;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_dst;
  logic [15:0] Stall_count;

  int n_chk = 0;
  int n_fail = 0;

  hazard_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .ID_valid(ID_valid),
    .ID_OPcode(ID_OPcode),
    .ID_rs(ID_rs),
    .ID_rt(ID_rt),
    .ID_rd(ID_rd),
    .Flush(Flush),
    .Stall(Stall),
    .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_dst(ID_EX_dst),
    .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_dst(EX_MEM_dst),
    .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_dst(MEM_WB_dst),
    .Stall_count(Stall_count)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R  = 6'd0;
  localparam logic [5:0] AI = 6'd8;
  localparam logic [5:0] LW = 6'd35;
  localparam logic [5:0] SW = 6'd43;
  localparam logic [5:0] BQ = 6'd4;
  localparam logic [5:0] JX = 6'd2;

  // model: history of the three instructions issued after ID
  bit       m_we [3] = '{0, 0, 0};
  bit [4:0] m_dst [3] = '{0, 0, 0};
  bit       m_ld = 0;
  int       m_cnt = 0;
  bit       m_prev_stall = 0;
  bit       preset_now = 0;

  function automatic bit writes(input logic [5:0] op);
    return op == R || op == AI || op == LW;
  endfunction

  function automatic bit uses_rt(input logic [5:0] op);
    return op == R || op == SW || op == BQ;
  endfunction

  function automatic bit [4:0] dest(input logic [5:0] op,
                                    input logic [4:0] rt,
                                    input logic [4:0] rd);
    if (op == R) return rd;
    if (op == AI || op == LW) return rt;
    return 5'd0;
  endfunction

  function automatic bit exp_stall();
    bit dep;
    dep = (m_dst[0] == ID_rs) ||
          (uses_rt(ID_OPcode) && m_dst[0] == ID_rt);
    return ID_valid && !Flush && m_ld && m_we[0] && dep;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit s;
    bit [4:0] d;
    if (rst) begin
      m_we = '{0, 0, 0};
      m_dst = '{0, 0, 0};
      m_ld = 0;
      m_cnt = 0;
      m_prev_stall = 0;
    end else begin
      s = exp_stall();
      m_prev_stall = s;
      m_we[2] = m_we[1];
      m_dst[2] = m_dst[1];
      m_we[1] = m_we[0];
      m_dst[1] = m_dst[0];
      if (s || Flush) begin
        m_we[0] = 0;
        m_dst[0] = 0;
        m_ld = 0;
      end else begin
        d = dest(ID_OPcode, ID_rt, ID_rd);
        m_dst[0] = d;
        m_we[0] = ID_valid && writes(ID_OPcode) && d != 0;
        m_ld = ID_valid && ID_OPcode == LW;
      end
      if (s) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (preset_now) begin
        #1;
        dut.stall_cnt_q = 16'hFFFD;
        m_cnt = 65533;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("stall", {31'd0, Stall}, {31'd0, exp_stall()});
    chk("idex_we", {31'd0, ID_EX_RegWrite}, {31'd0, m_we[0]});
    chk("idex_dst", {27'd0, ID_EX_dst}, {27'd0, m_dst[0]});
    chk("exmem_we", {31'd0, EX_MEM_RegWrite}, {31'd0, m_we[1]});
    chk("exmem_dst", {27'd0, EX_MEM_dst}, {27'd0, m_dst[1]});
    chk("memwb_we", {31'd0, MEM_WB_RegWrite}, {31'd0, m_we[2]});
    chk("memwb_dst", {27'd0, MEM_WB_dst}, {27'd0, m_dst[2]});
    chk("count", {16'd0, Stall_count}, m_cnt);
  end

  task automatic issue(input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic fl);
    @(posedge clk);
    #1;
    ID_valid = v;
    ID_OPcode = op;
    ID_rs = rs;
    ID_rt = rt;
    ID_rd = rd;
    Flush = fl;
    #2;
  endtask

  task automatic nop();
    issue(0, JX, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    ID_valid = 0;
    Flush = 0;
    @(posedge clk);
    #1;
    rst = 0;
    #2;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, Stall}, 0);
    chk({tag, "_we"}, {29'd0, ID_EX_RegWrite,
        EX_MEM_RegWrite, MEM_WB_RegWrite}, 0);
    chk({tag, "_dst"}, {17'd0, ID_EX_dst,
        EX_MEM_dst, MEM_WB_dst}, 0);
    chk({tag, "_cnt"}, {16'd0, Stall_count}, 0);
  endtask

  initial begin
    do_reset();
    all_zero("reset");

    // add r3 flows down the pipe
    issue(1, R, 1, 2, 3, 0);
    chk("add_stall", {31'd0, Stall}, 0);
    nop();
    chk("add_idex", {26'd0, ID_EX_RegWrite, ID_EX_dst}, 32'h23);
    nop();
    chk("add_exmem", {26'd0, EX_MEM_RegWrite, EX_MEM_dst}, 32'h23);
    nop();
    chk("add_memwb", {26'd0, MEM_WB_RegWrite, MEM_WB_dst}, 32'h23);

    // lw r5 ; add r8 = r5 + r6
    do_reset();
    issue(1, LW, 1, 5, 0, 0);
    issue(1, R, 5, 6, 8, 0);
    chk("lu_stall", {31'd0, Stall}, 1);
    issue(1, R, 5, 6, 8, 0);
    chk("lu_release", {31'd0, Stall}, 0);
    chk("lu_bubble", {26'd0, ID_EX_RegWrite, ID_EX_dst}, 0);
    chk("lu_cnt", {16'd0, Stall_count}, 1);
    nop();
    chk("lu_add", {26'd0, ID_EX_RegWrite, ID_EX_dst}, 32'h28);

    // addi does not read rt; sw does
    do_reset();
    issue(1, LW, 1, 5, 0, 0);
    issue(1, AI, 2, 5, 0, 0);
    chk("addi_nostall", {31'd0, Stall}, 0);
    issue(1, LW, 1, 5, 0, 0);
    issue(1, SW, 1, 5, 0, 0);
    chk("sw_stall", {31'd0, Stall}, 1);

    // load to $0
    do_reset();
    issue(1, LW, 1, 0, 0, 0);
    issue(1, R, 0, 0, 4, 0);
    chk("z_stall", {31'd0, Stall}, 0);
    chk("z_we", {31'd0, ID_EX_RegWrite}, 0);

    // flush beats stall
    do_reset();
    issue(1, LW, 1, 7, 0, 0);
    issue(1, R, 7, 1, 9, 1);
    chk("fl_stall", {31'd0, Stall}, 0);
    nop();
    chk("fl_bubble", {26'd0, ID_EX_RegWrite, ID_EX_dst}, 0);
    chk("fl_cnt", {16'd0, Stall_count}, 0);

    // reset during a stall
    do_reset();
    issue(1, LW, 1, 5, 0, 0);
    issue(1, R, 5, 6, 8, 0);
    chk("rs_pre", {31'd0, Stall}, 1);
    #1 rst = 1;
    #1 all_zero("rst_mid");
    @(posedge clk);
    #1 rst = 0;
    nop();
    chk("rs_capture", {26'd0, ID_EX_RegWrite, ID_EX_dst}, 32'h28);

    // saturation
    do_reset();
    nop();
    preset_now = 1;
    nop();
    preset_now = 0;
    chk("sat_preset", {16'd0, Stall_count}, 32'hFFFD);
    for (int i = 0; i < 12; i++) issue(1, LW, 5, 5, 0, 0);
    chk("sat_hold", {16'd0, Stall_count}, 32'hFFFF);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] ops [6];
      ops = '{R, AI, LW, SW, BQ, 6'($urandom)};
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      if (!m_prev_stall) begin
        ID_valid = ($urandom_range(0, 9) != 0);
        ID_OPcode = ops[$urandom_range(0, 5)];
        ID_rs = 5'($urandom_range(0, 7));
        ID_rt = 5'($urandom_range(0, 7));
        ID_rd = 5'($urandom_range(0, 7));
      end
      Flush = ($urandom_range(0, 9) == 0);
      #2;
    end
    @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
